// File: rtl/aes_round_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_sequencer_if
//  Description : Bundle of the AES round sequencer's request channel, key
//                store port, round datapath port and result channel.
//                slave  = sequencer side, master = surrounding system side.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_round_sequencer_if;
  // request channel
  logic         start_i;
  logic         decrypt_i;
  logic [127:0] block_i;
  logic         ready_o;
  // key store
  logic [3:0]   key_idx_o;
  logic [127:0] key_i;
  // shared round datapath
  logic         rnd_valid_o;
  logic         rnd_last_o;
  logic [127:0] rnd_data_o;
  logic [127:0] rnd_data_i;
  // result channel
  logic         out_valid_o;
  logic         out_ready_i;
  logic [127:0] data_o;

  modport slave (
    input  start_i, decrypt_i, block_i, key_i, rnd_data_i, out_ready_i,
    output ready_o, key_idx_o, rnd_valid_o, rnd_last_o, rnd_data_o,
           out_valid_o, data_o
  );

  modport master (
    output start_i, decrypt_i, block_i, key_i, rnd_data_i, out_ready_i,
    input  ready_o, key_idx_o, rnd_valid_o, rnd_last_o, rnd_data_o,
           out_valid_o, data_o
  );
endinterface
`default_nettype wire

// File: rtl/aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : aes_round_sequencer
//  Description : Iterative AES controller. Applies the initial AddRoundKey,
//                then drives a shared round datapath NR times (fixed latency
//                per round), flagging the final round. Decrypt walks the
//                round keys from NR down to 0.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_round_sequencer #(
  parameter int NR        = 10,
  parameter int ROUND_LAT = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  aes_round_sequencer_if.slave  bus
);

  // Latency counter only needs to reach ROUND_LAT-1.
  localparam int             LW         = (ROUND_LAT > 1) ? $clog2(ROUND_LAT) : 1;
  localparam logic [LW-1:0]  c_LAT_LAST = LW'(ROUND_LAT - 1);
  localparam logic [3:0]     c_NR       = 4'(NR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t         r_fsm;
  state_t         w_fsm_nxt;

  logic           r_dec;
  logic [127:0]   r_st;
  logic [3:0]     r_r;
  logic [LW-1:0]  r_lat;
  logic [127:0]   r_data;

  logic           w_lat_done;
  logic           w_final;
  logic [3:0]     w_rkey_idx;
  logic           w_ready;
  logic           w_rnd_valid;
  logic           w_rnd_last;
  logic [3:0]     w_key_idx;
  logic [127:0]   w_rnd_data;
  logic           w_out_valid;

  assign w_lat_done = (r_lat == c_LAT_LAST);
  assign w_final    = (r_r == c_NR);
  // Decrypt consumes round keys in reverse order.
  assign w_rkey_idx = r_dec ? (c_NR - r_r) : r_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_fsm <= S_IDLE;
    else     r_fsm <= w_fsm_nxt;
  end

  // Next-state and output decode; round outputs stay put through WAIT so the
  // datapath's registered key and data remain coherent.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_ready     = 1'b0;
    w_rnd_valid = 1'b0;
    w_rnd_last  = 1'b0;
    w_key_idx   = 4'd0;
    w_rnd_data  = 128'd0;
    w_out_valid = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        w_ready = 1'b1;
        if (bus.start_i) w_fsm_nxt = S_INIT;
      end
      S_INIT: begin
        w_key_idx = r_dec ? c_NR : 4'd0;
        w_fsm_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        w_rnd_valid = 1'b1;
        w_rnd_data  = r_st;
        w_key_idx   = w_rkey_idx;
        w_rnd_last  = w_final;
        w_fsm_nxt   = S_WAIT;
      end
      S_WAIT: begin
        w_rnd_data  = r_st;
        w_key_idx   = w_rkey_idx;
        w_rnd_last  = w_final;
        if (w_lat_done) w_fsm_nxt = w_final ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready_i) w_fsm_nxt = S_IDLE;
      end
      default: w_fsm_nxt = S_IDLE;
    endcase
  end

  // Block state, round counter, latency counter and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec  <= 1'b0;
      r_st   <= 128'd0;
      r_r    <= 4'd0;
      r_lat  <= '0;
      r_data <= 128'd0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (bus.start_i) begin
            r_st  <= bus.block_i;
            r_dec <= bus.decrypt_i;
            r_r   <= 4'd0;
          end
        end
        S_INIT: begin
          r_st <= r_st ^ bus.key_i;
          r_r  <= 4'd1;
        end
        S_ISSUE: begin
          r_lat <= '0;
        end
        S_WAIT: begin
          r_lat <= r_lat + LW'(1);
          if (w_lat_done) begin
            r_st <= bus.rnd_data_i;
            if (w_final) r_data <= bus.rnd_data_i;
            else         r_r    <= r_r + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.key_idx_o   = w_key_idx;
  assign bus.rnd_valid_o = w_rnd_valid;
  assign bus.rnd_last_o  = w_rnd_last;
  assign bus.rnd_data_o  = w_rnd_data;
  assign bus.out_valid_o = w_out_valid;
  assign bus.data_o      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_round_sequencer
//  Description : Directed bench for aes_round_sequencer. DUT1 (NR=10,
//                ROUND_LAT=2) is paired with an AES-128 round model and key
//                store; DUT2 (NR=14, ROUND_LAT=1) uses a toy round function.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_round_sequencer;

  localparam int LAT1 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  aes_round_sequencer_if if1 ();
  aes_round_sequencer_if if2 ();

  aes_round_sequencer #(.NR(10), .ROUND_LAT(LAT1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  aes_round_sequencer #(.NR(14), .ROUND_LAT(1)) u_dut14 (
    .clk (clk),
    .rst (rst),
    .bus (if2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  logic [7:0]   sbox  [256];
  logic [7:0]   isbox [256];
  logic [127:0] rk1   [16];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p = 8'h00; aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(x));
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
      isbox[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++)
      rk1[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last, input logic dec);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   m [16];
    logic [127:0] o;
    for (int n = 0; n < 16; n++) a[n] = s[127-8*n -: 8];
    if (!dec) begin
      for (int n = 0; n < 16; n++) b[n] = sbox[a[4*(((n/4) + (n%4)) % 4) + (n%4)]];
      for (int c = 0; c < 4; c++) begin
        m[4*c]   = gmul(b[4*c], 8'h02) ^ gmul(b[4*c+1], 8'h03) ^ b[4*c+2] ^ b[4*c+3];
        m[4*c+1] = b[4*c] ^ gmul(b[4*c+1], 8'h02) ^ gmul(b[4*c+2], 8'h03) ^ b[4*c+3];
        m[4*c+2] = b[4*c] ^ b[4*c+1] ^ gmul(b[4*c+2], 8'h02) ^ gmul(b[4*c+3], 8'h03);
        m[4*c+3] = gmul(b[4*c], 8'h03) ^ b[4*c+1] ^ b[4*c+2] ^ gmul(b[4*c+3], 8'h02);
      end
      for (int n = 0; n < 16; n++) o[127-8*n -: 8] = (last ? b[n] : m[n]) ^ k[127-8*n -: 8];
    end else begin
      for (int n = 0; n < 16; n++)
        b[n] = isbox[a[4*(((n/4) - (n%4) + 4) % 4) + (n%4)]] ^ k[127-8*n -: 8];
      for (int c = 0; c < 4; c++) begin
        m[4*c]   = gmul(b[4*c],8'h0e) ^ gmul(b[4*c+1],8'h0b) ^ gmul(b[4*c+2],8'h0d) ^ gmul(b[4*c+3],8'h09);
        m[4*c+1] = gmul(b[4*c],8'h09) ^ gmul(b[4*c+1],8'h0e) ^ gmul(b[4*c+2],8'h0b) ^ gmul(b[4*c+3],8'h0d);
        m[4*c+2] = gmul(b[4*c],8'h0d) ^ gmul(b[4*c+1],8'h09) ^ gmul(b[4*c+2],8'h0e) ^ gmul(b[4*c+3],8'h0b);
        m[4*c+3] = gmul(b[4*c],8'h0b) ^ gmul(b[4*c+1],8'h0d) ^ gmul(b[4*c+2],8'h09) ^ gmul(b[4*c+3],8'h0e);
      end
      for (int n = 0; n < 16; n++) o[127-8*n -: 8] = last ? b[n] : m[n];
    end
    return o;
  endfunction

  // ---------------- DUT1 environment: key store + 2-stage round unit ----------------
  logic         mode1 = 1'b0;
  logic [127:0] p1a = 128'd0;
  logic [127:0] p1b = 128'd0;

  assign if1.key_i      = rk1[if1.key_idx_o];
  assign if1.rnd_data_i = p1b;

  always @(posedge clk) begin
    p1a <= if1.rnd_valid_o ? aes_round(if1.rnd_data_o, if1.key_i, if1.rnd_last_o, mode1) : 128'd0;
    p1b <= p1a;
  end

  // ---------------- DUT2 environment: toy key store + 1-stage round unit ----------------
  function automatic logic [127:0] key2(input logic [3:0] idx);
    return {32{idx}} ^ 128'h0123456789abcdef_fedcba9876543210;
  endfunction

  function automatic logic [127:0] f2(input logic [127:0] d, input logic [127:0] k, input logic last);
    return {d[126:0], d[127]} ^ k ^ {120'd0, (last ? 8'ha5 : 8'h00)};
  endfunction

  logic [127:0] p2 = 128'd0;
  assign if2.key_i      = key2(if2.key_idx_o);
  assign if2.rnd_data_i = p2;

  always @(posedge clk) begin
    p2 <= if2.rnd_valid_o ? f2(if2.rnd_data_o, if2.key_i, if2.rnd_last_o) : 128'd0;
  end

  // ---------------- monitors ----------------
  int           idx_q [$];
  logic         last_q [$];
  int           cnt2 = 0;
  int           last2 = 0;
  int           hold_n = 0;
  logic [3:0]   hold_idx;
  logic [127:0] hold_data;
  logic         hold_last;

  always @(negedge clk) begin
    if (rst) begin
      hold_n = 0;
    end else if (if1.rnd_valid_o) begin
      idx_q.push_back(int'(if1.key_idx_o));
      last_q.push_back(if1.rnd_last_o);
      hold_idx  = if1.key_idx_o;
      hold_data = if1.rnd_data_o;
      hold_last = if1.rnd_last_o;
      hold_n    = LAT1;
    end else if (hold_n > 0) begin
      check_val("wait_key_idx_stable", 128'(if1.key_idx_o), 128'(hold_idx));
      check_val("wait_rnd_data_stable", if1.rnd_data_o, hold_data);
      check_val("wait_rnd_last_stable", 128'(if1.rnd_last_o), 128'(hold_last));
      hold_n = hold_n - 1;
    end
    if (!rst && if2.rnd_valid_o) begin
      cnt2++;
      if (if2.rnd_last_o) last2++;
    end
  end

  // One block through DUT1: accept, latency, result, key-index sequence.
  task automatic run1(input logic dec, input logic [127:0] blk, input logic [127:0] exp);
    int lat;
    idx_q.delete();
    last_q.delete();
    @(posedge clk); #1;
    mode1 = dec;
    if1.decrypt_i = dec;
    if1.block_i   = blk;
    if1.start_i   = 1'b1;
    @(negedge clk);
    check_val("accept_ready", 128'(if1.ready_o), 128'd1);
    @(posedge clk); #1;
    if1.start_i   = 1'b0;
    if1.block_i   = ~blk;
    if1.decrypt_i = ~dec;
    lat = 1;
    @(negedge clk);
    check_val("init_key_idx", 128'(if1.key_idx_o), dec ? 128'd10 : 128'd0);
    check_val("init_not_ready", 128'(if1.ready_o), 128'd0);
    while (!if1.out_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    check_val("latency", 128'(lat), 128'd32);
    check_val("result", if1.data_o, exp);
    check_val("pulse_count", 128'(idx_q.size()), 128'd10);
    for (int i = 0; i < idx_q.size() && i < 10; i++) begin
      check_val("round_key_idx", 128'(idx_q[i]), dec ? 128'(9 - i) : 128'(i + 1));
      check_val("round_last", 128'(last_q[i]), (i == 9) ? 128'd1 : 128'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt, lat;
    logic [127:0] exp2, b2;
    rst = 1'b1;
    if1.start_i = 1'b0; if1.decrypt_i = 1'b0; if1.block_i = 128'd0; if1.out_ready_i = 1'b1;
    if2.start_i = 1'b0; if2.decrypt_i = 1'b0; if2.block_i = 128'd0; if2.out_ready_i = 1'b1;
    build_tables();
    expand_key(128'h000102030405060708090a0b0c0d0e0f);

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ready", 128'(if1.ready_o), 128'd1);
    check_val("rst_out_valid", 128'(if1.out_valid_o), 128'd0);
    check_val("rst_rnd_valid", 128'(if1.rnd_valid_o), 128'd0);
    check_val("rst_rnd_last", 128'(if1.rnd_last_o), 128'd0);
    check_val("rst_key_idx", 128'(if1.key_idx_o), 128'd0);
    check_val("rst_rnd_data", if1.rnd_data_o, 128'd0);
    check_val("rst_data", if1.data_o, 128'd0);
    check_val("rst_ready_dut2", 128'(if2.ready_o), 128'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset mid-WAIT aborts the block.
    @(posedge clk); #1;
    mode1 = 1'b0;
    if1.block_i = 128'h00112233445566778899aabbccddeeff;
    if1.start_i = 1'b1;
    @(posedge clk); #1;
    if1.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;           // cycle 3: WAIT
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("abort_ready", 128'(if1.ready_o), 128'd1);
    check_val("abort_out_valid", 128'(if1.out_valid_o), 128'd0);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (if1.rnd_valid_o || if1.out_valid_o) cnt++;
    end
    check_val("abort_quiet", 128'(cnt), 128'd0);

    // Encrypt and decrypt, FIPS-197 C.1.
    run1(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run1(1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff);

    // Backpressure on the result channel.
    @(posedge clk); #1;
    if1.out_ready_i = 1'b0;
    run1(1'b0, 128'h00112233445566778899aabbccddeeff, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if1.start_i = i[0];
      if1.block_i = 128'hdeadbeef;
      @(negedge clk);
      check_val("bp_out_valid", 128'(if1.out_valid_o), 128'd1);
      check_val("bp_data", if1.data_o, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      check_val("bp_not_ready", 128'(if1.ready_o), 128'd0);
    end
    @(posedge clk); #1;
    if1.start_i = 1'b0;
    if1.out_ready_i = 1'b1;
    @(negedge clk);
    check_val("bp_release_valid", 128'(if1.out_valid_o), 128'd1);
    @(posedge clk);
    @(negedge clk);
    check_val("bp_done_valid", 128'(if1.out_valid_o), 128'd0);
    check_val("bp_done_ready", 128'(if1.ready_o), 128'd1);
    idx_q.delete();
    repeat (5) @(negedge clk);
    check_val("bp_no_restart", 128'(idx_q.size()), 128'd0);

    // DUT2: NR=14, ROUND_LAT=1, start pulsed while busy.
    b2 = 128'hfedcba98765432100123456789abcdef;
    exp2 = b2 ^ key2(4'd0);
    for (int r = 1; r <= 14; r++) exp2 = f2(exp2, key2(4'(r)), r == 14);
    cnt2 = 0; last2 = 0;
    @(posedge clk); #1;
    if2.block_i = b2;
    if2.start_i = 1'b1;
    @(posedge clk); #1;
    if2.start_i = 1'b0;
    if2.block_i = 128'h5555;
    lat = 1;
    @(negedge clk);
    while (!if2.out_valid_o && lat < 200) begin
      @(negedge clk);
      lat++;
      if2.start_i = (lat >= 5 && lat <= 8);
    end
    if2.start_i = 1'b0;
    check_val("nr14_latency", 128'(lat), 128'd30);
    check_val("nr14_result", if2.data_o, exp2);
    check_val("nr14_pulses", 128'(cnt2), 128'd14);
    check_val("nr14_last", 128'(last2), 128'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (if2.out_valid_o) cnt++;
    end
    check_val("nr14_no_second", 128'(cnt), 128'd0);
    check_val("nr14_pulses_after", 128'(cnt2), 128'd14);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
